// File: rtl/poc_pkg.sv
// Shared definitions for the FIFO-buffered parallel output controller:
// register map, status-register bit positions and drain FSM states.
package poc_pkg;

  localparam logic [1:0] ADDR_SR    = 2'd0;
  localparam logic [1:0] ADDR_DATA  = 2'd1;
  localparam logic [1:0] ADDR_COUNT = 2'd2;
  localparam logic [1:0] ADDR_WMARK = 2'd3;

  // Status register read bits; OVF and FLUSH double as write-one command bits
  localparam int unsigned SR_NOT_FULL = 7;
  localparam int unsigned SR_EMPTY    = 6;
  localparam int unsigned SR_IRQ      = 5;
  localparam int unsigned SR_OVF      = 4;
  localparam int unsigned SR_FLUSH    = 3;
  localparam int unsigned SR_BUSY     = 2;
  localparam int unsigned SR_MODE     = 0;

  localparam int unsigned SR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } drain_state_e;

endpackage

// File: rtl/poc_sync_fifo.sv
// Synchronous FIFO with registered pointers and an occupancy count.
// Flush clears pointers and count; simultaneous push/pop while full is allowed.
module poc_sync_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [DW-1:0]          i_din,
  output logic [DW-1:0]          o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign pop_ok  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when a pop frees the head slot this cycle
  assign push_ok = i_push & ~i_flush & (~o_full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only valid entries are ever observed
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_din;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/poc_fifo_ctrl.sv
// Bus-mapped parallel printer controller: register decode, overflow/watermark
// status, level interrupt and an autonomous FIFO-to-printer drain FSM.
module poc_fifo_ctrl
  import poc_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [1:0]    i_addr,
  input  logic          i_rw,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  input  logic          i_mode,
  output logic          o_irq,
  input  logic          i_rdy,
  output logic          o_tr,
  output logic [DW-1:0] o_pd
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic            rd_en, wr_data, wr_sr, wr_wmark;
  logic            flush, ovf_clr, push_acc, drop, pop;
  logic            fifo_full, fifo_empty;
  logic [DW-1:0]   fifo_head;
  logic [CW-1:0]   fifo_count, count_nxt;
  logic [CW-1:0]   wmark_q, wmark_d;
  logic            ovf_q, ovf_d;
  logic            irq_q, irq_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            tr_q, tr_d;
  logic [DW-1:0]   pd_q, pd_d;
  logic [SR_W-1:0] sr;
  drain_state_e    state_q, state_d;

  assign rd_en    = i_en & ~i_rw;
  assign wr_data  = i_en & i_rw & (i_addr == ADDR_DATA);
  assign wr_sr    = i_en & i_rw & (i_addr == ADDR_SR);
  assign wr_wmark = i_en & i_rw & (i_addr == ADDR_WMARK);
  assign flush    = wr_sr & i_din[SR_FLUSH];
  assign ovf_clr  = wr_sr & i_din[SR_OVF];

  // Flush beats a concurrent push; a full FIFO accepts only alongside a pop
  assign push_acc = wr_data & ~flush & (~fifo_full | pop);
  assign drop     = wr_data & ~flush & fifo_full & ~pop;

  poc_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push_acc),
    .i_pop   (pop),
    .i_flush (flush),
    .i_din   (i_din),
    .o_head  (fifo_head),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Occupancy after this edge, used so the interrupt tracks the same edge as COUNT
  always_comb begin
    if (flush) count_nxt = '0;
    else       count_nxt = fifo_count + CW'(push_acc) - CW'(pop);
  end

  always_comb begin
    wmark_d = wmark_q;
    ovf_d   = ovf_q;
    if (wr_wmark) wmark_d = i_din[AW:0];
    if (ovf_clr)   ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
    irq_d = i_mode & (count_nxt <= wmark_d);
  end

  always_comb begin
    sr              = '0;
    sr[SR_NOT_FULL] = ~fifo_full;
    sr[SR_EMPTY]    = fifo_empty;
    sr[SR_IRQ]      = irq_q;
    sr[SR_OVF]      = ovf_q;
    sr[SR_BUSY]     = (state_q != IDLE);
    sr[SR_MODE]     = i_mode;
  end

  always_comb begin
    dout_d = dout_q;
    if (rd_en) begin
      unique case (i_addr)
        ADDR_SR:    dout_d = DW'(sr);
        ADDR_DATA:  dout_d = fifo_empty ? '0 : fifo_head;
        ADDR_COUNT: dout_d = DW'(fifo_count);
        ADDR_WMARK: dout_d = DW'(wmark_q);
        default:    dout_d = dout_q;
      endcase
    end
  end

  // Drain FSM: state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Drain FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty && i_rdy) state_d = REQ;
      REQ:     if (!i_rdy)               state_d = BUSY;
      BUSY:    if (i_rdy)                state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Drain FSM: outputs; o_pd is only reloaded from IDLE so it is stable while o_tr=1
  always_comb begin
    pop  = 1'b0;
    tr_d = tr_q;
    pd_d = pd_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && i_rdy) begin
          pop  = 1'b1;
          tr_d = 1'b1;
          pd_d = fifo_head;
        end
      end
      REQ:     if (!i_rdy) tr_d = 1'b0;
      BUSY:    tr_d = 1'b0;
      default: tr_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      dout_q  <= '0;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wmark_q <= '0;
      tr_q    <= 1'b0;
      pd_q    <= '0;
    end else begin
      dout_q  <= dout_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
      wmark_q <= wmark_d;
      tr_q    <= tr_d;
      pd_q    <= pd_d;
    end
  end

  assign o_dout = dout_q;
  assign o_irq  = irq_q;
  assign o_tr   = tr_q;
  assign o_pd   = pd_q;

endmodule

// File: tb/tb_poc_fifo_ctrl.sv
// Self-checking bench for poc_fifo_ctrl: queue-based reference model,
// printer handshake model and randomized bus traffic.
module tb_poc_fifo_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam logic [1:0] A_SR = 2'd0, A_DATA = 2'd1, A_COUNT = 2'd2, A_WM = 2'd3;

  logic          clk, rst_n, en, rw, mode, irq, tr;
  logic          tb_rdy, prn_rdy, prn_auto, rdy;
  logic [1:0]    addr;
  logic [DW-1:0] din, dout, pd;

  int            checks, errors, prn_hold;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sent[$];
  logic          m_ovf;
  logic [AW:0]   m_wm;

  assign rdy = prn_auto ? prn_rdy : tb_rdy;

  poc_fifo_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_addr(addr), .i_rw(rw),
    .i_din(din), .o_dout(dout), .i_mode(mode), .o_irq(irq),
    .i_rdy(rdy), .o_tr(tr), .o_pd(pd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Printer: drops rdy one cycle after seeing a request, raises it prn_hold cycles later
  initial begin
    prn_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (prn_auto && tr && prn_rdy) begin
        @(posedge clk); #1;
        prn_rdy = 1'b0;
        repeat (prn_hold) @(posedge clk);
        #1;
        prn_rdy = 1'b1;
      end
    end
  end

  // Records every character at the rising edge of o_tr and checks o_pd holds while o_tr=1
  initial begin
    logic          tr_prev;
    logic [DW-1:0] pd_prev;
    tr_prev = 1'b0;
    pd_prev = '0;
    forever begin
      @(posedge clk); #2;
      if (tr === 1'b1 && tr_prev === 1'b0) sent.push_back(pd);
      if (tr === 1'b1 && tr_prev === 1'b1) begin
        checks++;
        if (pd !== pd_prev) begin errors++; $display("FAIL pd_stable got %h need %h", pd, pd_prev); end
      end
      tr_prev = tr;
      pd_prev = pd;
    end
  end

  function automatic logic exp_irq();
    return mode & (mq.size() <= int'(m_wm));
  endfunction

  function automatic logic [7:0] exp_sr(input logic busy);
    logic [7:0] s;
    s    = 8'h00;
    s[7] = (mq.size() < int'(DEPTH));
    s[6] = (mq.size() == 0);
    s[5] = exp_irq();
    s[4] = m_ovf;
    s[2] = busy;
    s[0] = mode;
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [DW-1:0] d);
    addr = a; din = d; rw = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; rw = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [DW-1:0] d);
    addr = a; rw = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    d = dout;
  endtask

  // Model of a DATA write with no concurrent pop
  task automatic push_model(input logic [DW-1:0] d);
    if (mq.size() < int'(DEPTH)) mq.push_back(d);
    else m_ovf = 1'b1;
  endtask

  task automatic wait_sent(input int n, input int budget);
    int c;
    c = 0;
    while (sent.size() < n && c < budget) begin tick(1); c++; end
    checks++;
    if (sent.size() < n) begin errors++; $display("FAIL wait_sent got %0d chars need %0d", sent.size(), n); end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (!(rdy === 1'b1 && tr === 1'b0) && c < 60) begin tick(1); c++; end
    checks++;
    if (c >= 60) begin errors++; $display("FAIL wait_idle got tr=%b rdy=%b need tr=0 rdy=1", tr, rdy); end
    tick(2);
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    rst_n = 1'b0;
    tick(3);
    checks++; if (dout !== '0) begin errors++; $display("FAIL rst_dout got %h need 00", dout); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b need 0", irq); end
    checks++; if (tr !== 1'b0) begin errors++; $display("FAIL rst_tr got %b need 0", tr); end
    checks++; if (pd !== '0) begin errors++; $display("FAIL rst_pd got %h need 00", pd); end
    rst_n = 1'b1;
    tick(1);
    bus_rd(A_COUNT, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_count got %h need 00", v); end
    bus_rd(A_SR, v);
    checks++; if (v !== 8'hC0) begin errors++; $display("FAIL rst_sr got %h need c0", v); end
    bus_rd(A_WM, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_wmark got %h need 00", v); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] v;
    logic [DW-1:0] ex[3];
    ex[0] = 8'h41; ex[1] = 8'h42; ex[2] = 8'h43;
    prn_hold = 4; prn_auto = 1'b1;
    sent.delete();
    bus_wr(A_DATA, 8'h41);
    checks++; if (tr !== 1'b0) begin errors++; $display("FAIL first_tr_early got %b need 0", tr); end
    tick(1);
    checks++; if (tr !== 1'b1 || pd !== 8'h41) begin errors++; $display("FAIL first_tr_latency got tr=%b pd=%h need tr=1 pd=41", tr, pd); end
    bus_wr(A_DATA, 8'h42);
    bus_wr(A_DATA, 8'h43);
    wait_sent(3, 200);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sent.size() <= i || sent[i] !== ex[i]) begin
        errors++; $display("FAIL basic_seq[%0d] got %h need %h", i, (sent.size() > i) ? sent[i] : 8'hxx, ex[i]);
      end
    end
    wait_idle();
    bus_rd(A_COUNT, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL basic_count got %h need 00", v); end
    bus_rd(A_SR, v);
    checks++; if (v !== exp_sr(1'b0)) begin errors++; $display("FAIL basic_sr got %h need %h", v, exp_sr(1'b0)); end
    prn_auto = 1'b0;
  endtask

  task automatic test_overflow();
    logic [DW-1:0] v, d;
    tb_rdy = 1'b0;
    tick(1);
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      d = DW'($urandom);
      bus_wr(A_DATA, d);
      push_model(d);
    end
    bus_rd(A_COUNT, v);
    checks++; if (v !== DW'(mq.size()) || v !== DW'(DEPTH)) begin errors++; $display("FAIL ovf_count got %0d need %0d", v, DEPTH); end
    bus_rd(A_SR, v);
    checks++; if (v !== exp_sr(1'b0) || v[7] !== 1'b0 || v[4] !== 1'b1) begin errors++; $display("FAIL ovf_sr got %h need %h", v, exp_sr(1'b0)); end
    bus_rd(A_DATA, v);
    checks++; if (v !== mq[0]) begin errors++; $display("FAIL ovf_head got %h need %h", v, mq[0]); end
    bus_wr(A_SR, 8'h10);
    m_ovf = 1'b0;
    bus_rd(A_SR, v);
    checks++; if (v !== exp_sr(1'b0) || v[4] !== 1'b0) begin errors++; $display("FAIL ovf_clear got %h need %h", v, exp_sr(1'b0)); end
  endtask

  task automatic test_push_pop_full();
    logic [DW-1:0] v, d, popped;
    logic [DW-1:0] ex[$];
    d = DW'($urandom);
    popped = mq.pop_front();
    mq.push_back(d);
    ex.push_back(popped);
    foreach (mq[i]) ex.push_back(mq[i]);
    sent.delete();
    tb_rdy = 1'b1;
    bus_wr(A_DATA, d);
    checks++; if (tr !== 1'b1 || pd !== popped) begin errors++; $display("FAIL pp_tr got tr=%b pd=%h need tr=1 pd=%h", tr, pd, popped); end
    prn_hold = 3; prn_auto = 1'b1;
    bus_rd(A_COUNT, v);
    checks++; if (v !== DW'(DEPTH)) begin errors++; $display("FAIL pp_count got %0d need %0d", v, DEPTH); end
    bus_rd(A_SR, v);
    checks++; if (v[4] !== 1'b0 || v[7] !== 1'b0) begin errors++; $display("FAIL pp_sr got %h need ovf=0 not_full=0", v); end
    wait_sent(int'(DEPTH) + 1, 600);
    foreach (ex[i]) begin
      checks++;
      if (sent.size() <= i || sent[i] !== ex[i]) begin
        errors++; $display("FAIL pp_seq[%0d] got %h need %h", i, (sent.size() > i) ? sent[i] : 8'hxx, ex[i]);
      end
    end
    wait_idle();
    mq.delete();
    prn_auto = 1'b0;
  endtask

  task automatic test_irq(input logic md);
    logic [DW-1:0] v, d, popped;
    logic got;
    mode = md; tb_rdy = 1'b0;
    bus_wr(A_WM, 8'hE2);
    m_wm = 5'h02;
    checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL irq_wm mode=%b got %b need %b", md, irq, exp_irq()); end
    bus_rd(A_WM, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL irq_wm_read got %h need 02", v); end
    for (int i = 0; i < 4; i++) begin
      d = DW'($urandom);
      bus_wr(A_DATA, d);
      push_model(d);
      checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL irq_push mode=%b cnt=%0d got %b need %b", md, mq.size(), irq, exp_irq()); end
    end
    for (int k = 0; k < 4; k++) begin
      tb_rdy = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
        tick(1);
        if (tr === 1'b1) begin
          got = 1'b1;
          popped = mq.pop_front();
          checks++; if (pd !== popped) begin errors++; $display("FAIL irq_pd got %h need %h", pd, popped); end
        end
        checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL irq_drain mode=%b cnt=%0d got %b need %b", md, mq.size(), irq, exp_irq()); end
      end
      checks++; if (!got) begin errors++; $display("FAIL irq_tr_timeout got tr=%b need 1", tr); end
      tb_rdy = 1'b0;
      tick(1);
      checks++; if (tr !== 1'b0) begin errors++; $display("FAIL irq_tr_drop got %b need 0", tr); end
    end
    tb_rdy = 1'b1;
    tick(2);
  endtask

  task automatic test_flush();
    logic [DW-1:0] v, inflight;
    int c;
    mode = 1'b0; tb_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = DW'($urandom);
      bus_wr(A_DATA, v);
      push_model(v);
    end
    sent.delete();
    tb_rdy = 1'b1;
    c = 0;
    while (tr !== 1'b1 && c < 4) begin tick(1); c++; end
    inflight = mq.pop_front();
    bus_wr(A_SR, 8'h08);
    mq.delete();
    checks++; if (tr !== 1'b1 || pd !== inflight) begin errors++; $display("FAIL flush_inflight got tr=%b pd=%h need tr=1 pd=%h", tr, pd, inflight); end
    bus_rd(A_COUNT, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL flush_count got %h need 00", v); end
    tb_rdy = 1'b0;
    tick(1);
    checks++; if (tr !== 1'b0) begin errors++; $display("FAIL flush_tr_drop got %b need 0", tr); end
    tb_rdy = 1'b1;
    tick(12);
    checks++; if (sent.size() !== 1 || sent[0] !== inflight) begin errors++; $display("FAIL flush_sent got %0d chars need 1 (%h)", sent.size(), inflight); end
    // Flush on the same edge as the FSM pop
    tb_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = DW'($urandom);
      bus_wr(A_DATA, v);
      push_model(v);
    end
    sent.delete();
    inflight = mq[0];
    tb_rdy = 1'b1;
    bus_wr(A_SR, 8'h08);
    mq.delete();
    checks++; if (tr !== 1'b1 || pd !== inflight) begin errors++; $display("FAIL flushpop_tr got tr=%b pd=%h need tr=1 pd=%h", tr, pd, inflight); end
    bus_rd(A_COUNT, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL flushpop_count got %h need 00", v); end
    tb_rdy = 1'b0;
    tick(1);
    tb_rdy = 1'b1;
    tick(10);
    checks++; if (sent.size() !== 1 || sent[0] !== inflight) begin errors++; $display("FAIL flushpop_sent got %0d chars need 1 (%h)", sent.size(), inflight); end
  endtask

  task automatic test_random();
    logic [DW-1:0] v, d, ev;
    logic [1:0]    a;
    logic [DW-1:0] ex[$];
    int            r;
    mode = 1'($urandom_range(0, 1));
    tb_rdy = 1'b0;
    tick(1);
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        d = DW'($urandom);
        bus_wr(A_DATA, d);
        push_model(d);
      end else if (r == 5) begin
        d = DW'($urandom);
        if ($urandom_range(0, 3) != 0) d[3] = 1'b0;
        bus_wr(A_SR, d);
        if (d[4]) m_ovf = 1'b0;
        if (d[3]) mq.delete();
      end else if (r == 6) begin
        d = DW'($urandom);
        bus_wr(A_WM, d);
        m_wm = d[AW:0];
      end else if (r == 7) begin
        bus_wr(A_COUNT, DW'($urandom));
      end else begin
        a = 2'($urandom_range(0, 3));
        bus_rd(a, v);
        case (a)
          A_SR:    ev = exp_sr(1'b0);
          A_DATA:  ev = (mq.size() > 0) ? mq[0] : 8'h00;
          A_COUNT: ev = DW'(mq.size());
          default: ev = DW'(m_wm);
        endcase
        checks++; if (v !== ev) begin errors++; $display("FAIL rnd_read addr=%0d got %h need %h", a, v, ev); end
      end
      checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL rnd_irq op=%0d got %b need %b", i, irq, exp_irq()); end
    end
    foreach (mq[i]) ex.push_back(mq[i]);
    sent.delete();
    prn_hold = $urandom_range(1, 5);
    prn_auto = 1'b1;
    wait_sent(ex.size(), 700);
    foreach (ex[i]) begin
      checks++;
      if (sent.size() <= i || sent[i] !== ex[i]) begin
        errors++; $display("FAIL rnd_seq[%0d] got %h need %h", i, (sent.size() > i) ? sent[i] : 8'hxx, ex[i]);
      end
    end
    wait_idle();
    mq.delete();
    prn_auto = 1'b0;
    tb_rdy = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] v;
    int c;
    tb_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = DW'($urandom);
      bus_wr(A_DATA, v);
      push_model(v);
    end
    tb_rdy = 1'b1;
    c = 0;
    while (tr !== 1'b1 && c < 4) begin tick(1); c++; end
    checks++; if (tr !== 1'b1) begin errors++; $display("FAIL rstmid_pre_tr got %b need 1", tr); end
    rst_n = 1'b0;
    tick(1);
    mq.delete(); m_ovf = 1'b0; m_wm = '0;
    checks++; if (tr !== 1'b0 || pd !== '0) begin errors++; $display("FAIL rstmid_tr got tr=%b pd=%h need tr=0 pd=00", tr, pd); end
    rst_n = 1'b1;
    tick(1);
    bus_rd(A_COUNT, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL rstmid_count got %h need 00", v); end
    bus_rd(A_SR, v);
    checks++; if (v !== exp_sr(1'b0) || v[2] !== 1'b0) begin errors++; $display("FAIL rstmid_sr got %h need %h", v, exp_sr(1'b0)); end
  endtask

  initial begin
    checks = 0; errors = 0; prn_hold = 4; prn_auto = 1'b0; tb_rdy = 1'b0;
    en = 1'b0; rw = 1'b0; addr = 2'd0; din = '0; mode = 1'b0; rst_n = 1'b0;
    m_ovf = 1'b0; m_wm = '0;
    mq.delete(); sent.delete();
    test_reset();
    test_basic();
    test_overflow();
    test_push_pop_full();
    test_irq(1'b1);
    test_irq(1'b0);
    test_flush();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
